// File: rtl/prog_freq_divider.sv
// rtl/prog_freq_divider.sv - runtime-programmable clock divider with boundary-aligned divisor load
// Optional PFD_ODD_DUTY_EN adds a negedge stage giving 50 % duty for odd ratios.
module prog_freq_divider #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             load,
    output logic             clk_out,
    output logic             tick,
    output logic             pending,
    output logic             err
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nx;
    logic [WIDTH-1:0] r_div_act;
    logic [WIDTH-1:0] w_div_act_nx;
    logic [WIDTH-1:0] r_div_pend;
    logic [WIDTH-1:0] w_div_pend_nx;
    logic             r_pending;
    logic             w_pending_nx;
    logic             r_pos_q;
    logic             w_pos_nx;
    logic             r_tick;
    logic             w_tick_nx;
    logic             r_err;
    logic             w_err_nx;
    logic             w_load_ok;
    logic             w_apply;
    logic             w_run;
    logic             w_wrap;

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = '0;
        w_apply       = 1'b0;
        w_run         = 1'b0;
        w_wrap        = (r_cnt == r_div_act - WIDTH'(1));
        w_load_ok     = load && (div_in >= WIDTH'(2));
        w_err_nx      = load && !w_load_ok;

        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nx = ST_RUN;
                    w_apply    = r_pending;
                    w_run      = 1'b1;
                end
            end
            ST_RUN: begin
                if (en) begin
                    w_cnt_nx = w_wrap ? '0 : r_cnt + WIDTH'(1);
                    w_apply  = w_wrap && r_pending;
                    w_run    = 1'b1;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase

        // A load on the boundary edge itself becomes pending for the following boundary
        w_div_act_nx  = w_apply ? r_div_pend : r_div_act;
        w_pending_nx  = w_load_ok ? 1'b1 : (w_apply ? 1'b0 : r_pending);
        w_div_pend_nx = w_load_ok ? div_in : r_div_pend;
        w_pos_nx      = w_run && (w_cnt_nx < (w_div_act_nx >> 1));
        w_tick_nx     = (r_state == ST_RUN) && en && (w_cnt_nx == r_div_act - WIDTH'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_div_act  <= WIDTH'(DEFAULT_DIV);
            r_div_pend <= WIDTH'(DEFAULT_DIV);
            r_pending  <= 1'b0;
            r_pos_q    <= 1'b0;
            r_tick     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_div_act  <= w_div_act_nx;
            r_div_pend <= w_div_pend_nx;
            r_pending  <= w_pending_nx;
            r_pos_q    <= w_pos_nx;
            r_tick     <= w_tick_nx;
            r_err      <= w_err_nx;
        end
    end

`ifdef PFD_ODD_DUTY_EN
    // Half-cycle extension: holds the high phase until the negedge after pos_q drops
    logic r_neg_q;

    always_ff @(negedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
        end else begin
            r_neg_q <= r_pos_q;
        end
    end

    assign clk_out = r_pos_q | (r_neg_q & r_div_act[0]);
`else
    assign clk_out = r_pos_q;
`endif

    assign tick    = r_tick;
    assign pending = r_pending;
    assign err     = r_err;

endmodule
